// File: rtl/data_mem_responder.sv
// Word-organised data memory responding to a req/ready + rvalid/rready load/store port,
// with programmable wait states and misaligned/out-of-range error responses.
package riscv_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ALEN = 32;
endpackage

module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [ALEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_we,
  input  logic [3:0]      dmem_be,
  input  logic [2:0]      dmem_funct3,
  output logic            dmem_ready,
  output logic            dmem_rvalid,
  input  logic            dmem_rready,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_err
);
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ALEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_we;
  logic [3:0]        r_be;
  logic [2:0]        r_f3;
  logic              r_ready;
  logic              r_rvalid;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic [XLEN-1:0]   r_mem [DEPTH_WORDS];

  state_t            w_next_state;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_accept;
  logic              w_into_resp;
  logic [ALEN-1:0]   w_addr;
  logic [XLEN-1:0]   w_wdata;
  logic              w_we;
  logic [3:0]        w_be;
  logic [2:0]        w_f3;
  logic              w_mis;
  logic              w_oor;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [XLEN-1:0]   w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_next_rdata;
  logic              w_next_err;

  // In IDLE the access is decoded from the live inputs so zero-wait/error accesses resolve on accept.
  always_comb begin
    w_addr  = (r_state == S_IDLE) ? dmem_addr   : r_addr;
    w_wdata = (r_state == S_IDLE) ? dmem_wdata  : r_wdata;
    w_we    = (r_state == S_IDLE) ? dmem_we     : r_we;
    w_be    = (r_state == S_IDLE) ? dmem_be     : r_be;
    w_f3    = (r_state == S_IDLE) ? dmem_funct3 : r_f3;
    w_mis   = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
              ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    w_oor   = ({2'b00, w_addr[ALEN-1:2]} >= ALEN'(DEPTH_WORDS));
    w_err   = w_mis || w_oor;
    w_idx   = w_addr[IDX_W+1:2];
    w_word  = r_mem[w_idx];
    w_byte  = w_word[{w_addr[1:0], 3'b000} +: 8];
    w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h000000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = w_word;
    endcase
  end

  // Next-state, counter and response payload.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_into_resp  = 1'b0;
    w_next_rdata = r_rdata;
    w_next_err   = r_err;
    case (r_state)
      S_IDLE: begin
        if (dmem_req) begin
          w_accept = 1'b1;
          if ((WAIT_STATES == 0) || w_err) begin
            w_next_state = S_RESP;
            w_into_resp  = 1'b1;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = S_RESP;
          w_into_resp  = 1'b1;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (dmem_rready) begin
          w_next_state = S_IDLE;
          w_next_rdata = '0;
          w_next_err   = 1'b0;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_into_resp) begin
      w_next_rdata = (w_err || w_we) ? '0 : w_load;
      w_next_err   = w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_f3     <= '0;
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_ready  <= (w_next_state == S_IDLE);
      r_rvalid <= (w_next_state == S_RESP);
      r_rdata  <= w_next_rdata;
      r_err    <= w_next_err;
      if (w_accept) begin
        r_addr  <= dmem_addr;
        r_wdata <= dmem_wdata;
        r_we    <= dmem_we;
        r_be    <= dmem_be;
        r_f3    <= dmem_funct3;
      end
    end
  end

  // Array has no reset; stores commit only when entering RESP without error.
  always_ff @(posedge clk) begin
    if (!rst && w_into_resp && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign dmem_ready  = r_ready;
  assign dmem_rvalid = r_rvalid;
  assign dmem_rdata  = r_rdata;
  assign dmem_err    = r_err;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL take parameter DEPTH_WORDS, default 1024, the number of 32-bit words in the internal data array.
REQ-002 SHALL take parameter WAIT_STATES, default 1, the extra cycles between accept and response; legal range is 0..7.
REQ-003 SHALL use XLEN=32 and ALEN from riscv_pkg for data and address widths.
REQ-004 clk  input  1  system clock; the block has one clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 dmem_req  input  1  access request valid.
REQ-007 dmem_addr  input  ALEN  byte address.
REQ-008 dmem_wdata  input  XLEN  store data, already lane-positioned by the initiator.
REQ-009 dmem_we  input  1  1=store, 0=load.
REQ-010 dmem_be  input  4  store byte-lane enables.
REQ-011 dmem_funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-012 dmem_ready  output  1  request accepted when dmem_req and dmem_ready are both high.
REQ-013 dmem_rvalid  output  1  response valid.
REQ-014 dmem_rready  input  1  response consumed when dmem_rvalid and dmem_rready are both high.
REQ-015 dmem_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-016 dmem_err  output  1  response is an error (misaligned or out-of-range access).

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 IDLE: dmem_ready=1 and dmem_rvalid=0; on accept, SHALL register addr, wdata, we, be and funct3.
REQ-019 On accept, IDLE SHALL go to RESP when WAIT_STATES=0 or the access is an error, else to WAIT with the counter loaded to WAIT_STATES-1.
REQ-020 WAIT: dmem_ready=0; the counter SHALL decrement each cycle, and the state SHALL go to RESP on the cycle the counter is 0.
REQ-021 Array access (read, or masked write) SHALL occur on the transition into RESP; accept-to-rvalid latency is WAIT_STATES+1 cycles.
REQ-022 RESP: dmem_rvalid=1 and dmem_ready=0; rdata and err SHALL be held stable until dmem_rready, then the state SHALL go to IDLE.
REQ-023 An accept is never possible in the same cycle as a response handshake; minimum spacing between accepts is WAIT_STATES+2 cycles.
REQ-024 Misaligned is defined as: funct3[1:0]=01 with addr[0]=1, or funct3[1:0]=10 with addr[1:0]!=0.
REQ-025 Out of range is defined as: addr[ALEN-1:2] >= DEPTH_WORDS.
REQ-026 An error access SHALL write nothing, return rdata=0 and err=1, and bypass WAIT.
REQ-027 Stores SHALL write only lanes with be[i]=1 (byte i is bits 8i+7:8i) at word index addr[ALEN-1:2]; rdata=0, err=0.
REQ-028 Loads SHALL select lane addr[1:0] for byte accesses and addr[1] for halfword accesses.
REQ-029 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL return the full word; funct3 011, 110 and 111 SHALL be treated as LW.
REQ-030 Input changes while not in IDLE SHALL be ignored.

Reset
REQ-031 While rst is high, at the clock edge the FSM SHALL go to IDLE and the counter SHALL clear; dmem_ready=0, dmem_rvalid=0, dmem_rdata=0 and dmem_err=0.
REQ-032 dmem_ready SHALL rise in the first cycle after rst deasserts.
REQ-033 Reset in WAIT SHALL abort the access with no write committed; reset in RESP SHALL drop the response.
REQ-034 Array contents SHALL NOT be cleared by reset.

Verification
REQ-035 WAIT_STATES=1: SW addr 0x10, wdata 0xDEADBEEF, be 1111 -> rvalid 2 cycles after accept with err=0; then LW 0x10 -> rdata 0xDEADBEEF.
REQ-036 SB addr 0x13, wdata 0x80000000, be 1000 -> LB 0x13 = 0xFFFFFF80, LBU 0x13 = 0x00000080, LW 0x10 = 0x80ADBEEF.
REQ-037 LH addr 0x11 -> err=1, rdata=0, rvalid 1 cycle after accept; SW 0x16 -> err=1 and memory is unchanged.
REQ-038 LW addr 4*DEPTH_WORDS -> err=1; rready held low 3 cycles -> rvalid, rdata and err remain stable and dmem_ready stays 0.
REQ-039 Reset asserted during WAIT of SW 0x20 -> next LW 0x20 returns the prior contents; outputs are 0 during reset and ready=1 the cycle after deassert.
REQ-040 WAIT_STATES=0 with back-to-back LW and rready tied high -> one accept every 2 cycles, rvalid asserted 1 cycle after each accept.
